// File: rtl/contador_ud_param.sv
// Parametrised up/down/ping-pong counter with runtime bounds, step, load and
// cycle-complete pulse; generalises the legacy 4-bit bouncing counter.
module contador_ud_param #(
    parameter int unsigned WIDTH      = 4,
    parameter logic [1:0]  MODO_RESET = 2'b10
) (
    input  logic             clock,
    input  logic             resert,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic             carga,
    input  logic [WIDTH-1:0] valor_carga,
    input  logic [WIDTH-1:0] passo,
    input  logic [WIDTH-1:0] limite_min,
    input  logic [WIDTH-1:0] limite_max,
    output logic [WIDTH-1:0] saida,
    output logic             direcao,
    output logic             fim_ciclo,
    output logic             erro
);

    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_PP   = 2'b10;
    localparam logic [1:0] MODO_HOLD = 2'b11;

    // Elaboration guard on parameter values.
    if (WIDTH == 0 || (MODO_RESET != MODO_UP && MODO_RESET != MODO_DOWN &&
                       MODO_RESET != MODO_PP && MODO_RESET != MODO_HOLD)) begin : g_bad_param
        $error("contador_ud_param: invalid parameters");
    end

    logic [W1-1:0]    s_x, mn_x, mx_x, p_x;
    logic [W1-1:0]    soma, min_mais_p, dif;
    logic [WIDTH-1:0] carga_clamp;
    logic             fora_faixa;
    logic [WIDTH-1:0] saida_n;
    logic             direcao_n;
    logic             fim_n;

    // Widened operands so sums and bound comparisons can never overflow.
    always_comb begin
        s_x        = W1'(saida);
        mn_x       = W1'(limite_min);
        mx_x       = W1'(limite_max);
        p_x        = W1'((passo == '0) ? WIDTH'(1) : passo);
        soma       = s_x + p_x;
        min_mais_p = mn_x + p_x;
        dif        = s_x - p_x;
    end

    assign erro = (limite_min > limite_max);

    assign fora_faixa = (saida < limite_min) || (saida > limite_max);

    always_comb begin
        if (valor_carga < limite_min)      carga_clamp = limite_min;
        else if (valor_carga > limite_max) carga_clamp = limite_max;
        else                               carga_clamp = valor_carga;
    end

    // Next-state selection in priority order: bound fault, load, range fix, count.
    always_comb begin
        saida_n   = saida;
        direcao_n = direcao;
        fim_n     = 1'b0;
        if (erro) begin
            saida_n   = saida;
        end else if (carga) begin
            saida_n   = carga_clamp;
        end else if (enable && (modo != MODO_HOLD)) begin
            if (fora_faixa) begin
                saida_n   = limite_min;
                direcao_n = 1'b0;
            end else begin
                case (modo)
                    MODO_UP: begin
                        direcao_n = 1'b0;
                        if (soma > mx_x) begin
                            saida_n = limite_min;
                            fim_n   = 1'b1;
                        end else begin
                            saida_n = WIDTH'(soma);
                        end
                    end
                    MODO_DOWN: begin
                        direcao_n = 1'b1;
                        if (s_x < min_mais_p) begin
                            saida_n = limite_max;
                            fim_n   = 1'b1;
                        end else begin
                            saida_n = WIDTH'(dif);
                        end
                    end
                    MODO_PP: begin
                        if (!direcao) begin
                            if (saida == limite_max) begin
                                saida_n   = (s_x < min_mais_p) ? limite_min : WIDTH'(dif);
                                direcao_n = 1'b1;
                            end else if (soma > mx_x) begin
                                saida_n = limite_max;
                            end else begin
                                saida_n = WIDTH'(soma);
                            end
                        end else begin
                            if (saida == limite_min) begin
                                saida_n   = (soma > mx_x) ? limite_max : WIDTH'(soma);
                                direcao_n = 1'b0;
                                fim_n     = 1'b1;
                            end else if (s_x < min_mais_p) begin
                                saida_n = limite_min;
                            end else begin
                                saida_n = WIDTH'(dif);
                            end
                        end
                    end
                    default: begin
                        saida_n = saida;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resert) begin
            saida     <= '0;
            direcao   <= 1'b0;
            fim_ciclo <= 1'b0;
        end else begin
            saida     <= saida_n;
            direcao   <= direcao_n;
            fim_ciclo <= fim_n;
        end
    end

endmodule

// File: tb/tb_contador_ud_param.sv
// Directed self-checking bench for contador_ud_param (WIDTH=4).
module tb_contador_ud_param;

    localparam int unsigned WIDTH = 4;

    logic             clock;
    logic             resert;
    logic             enable;
    logic [1:0]       modo;
    logic             carga;
    logic [WIDTH-1:0] valor_carga;
    logic [WIDTH-1:0] passo;
    logic [WIDTH-1:0] limite_min;
    logic [WIDTH-1:0] limite_max;
    logic [WIDTH-1:0] saida;
    logic             direcao;
    logic             fim_ciclo;
    logic             erro;

    int errors;
    int checks;

    contador_ud_param #(.WIDTH(WIDTH), .MODO_RESET(2'b10)) dut (
        .clock      (clock),
        .resert     (resert),
        .enable     (enable),
        .modo       (modo),
        .carga      (carga),
        .valor_carga(valor_carga),
        .passo      (passo),
        .limite_min (limite_min),
        .limite_max (limite_max),
        .saida      (saida),
        .direcao    (direcao),
        .fim_ciclo  (fim_ciclo),
        .erro       (erro)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_state(input string tag, input int es, input int ed, input int ef);
        check({tag, ".saida"}, int'(saida), es);
        check({tag, ".direcao"}, int'(direcao), ed);
        check({tag, ".fim_ciclo"}, int'(fim_ciclo), ef);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        clock       = 1'b0;
        resert      = 1'b1;
        enable      = 1'b0;
        modo        = 2'b10;
        carga       = 1'b0;
        valor_carga = '0;
        passo       = 4'd1;
        limite_min  = 4'd0;
        limite_max  = 4'd15;
        step();
        step();
        expect_state("reset", 0, 0, 0);
        check("reset.erro", int'(erro), 0);

        // Legacy bouncing sequence 0..15..0,1
        resert = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            expect_state($sformatf("legacy_up%0d", i), i, 0, 0);
        end
        for (int i = 14; i >= 0; i--) begin
            step();
            expect_state($sformatf("legacy_dn%0d", i), i, 1, 0);
        end
        step();
        expect_state("legacy_turn", 1, 0, 1);

        // Up-wrap min=3 max=12 step=4
        modo        = 2'b00;
        limite_min  = 4'd3;
        limite_max  = 4'd12;
        passo       = 4'd4;
        carga       = 1'b1;
        valor_carga = 4'd3;
        step();
        expect_state("upw_load", 3, 0, 0);
        carga = 1'b0;
        step(); expect_state("upw_7", 7, 0, 0);
        step(); expect_state("upw_11", 11, 0, 0);
        step(); expect_state("upw_wrap", 3, 0, 1);
        step(); expect_state("upw_7b", 7, 0, 0);

        // Down-wrap min=2 max=9 step=3
        modo        = 2'b01;
        limite_min  = 4'd2;
        limite_max  = 4'd9;
        passo       = 4'd3;
        carga       = 1'b1;
        valor_carga = 4'd9;
        step();
        expect_state("dnw_load", 9, 0, 0);
        carga = 1'b0;
        step(); expect_state("dnw_6", 6, 1, 0);
        step(); expect_state("dnw_3", 3, 1, 0);
        step(); expect_state("dnw_wrap", 9, 1, 1);

        // Ping-pong with clamping at both bounds
        modo        = 2'b10;
        carga       = 1'b1;
        valor_carga = 4'd2;
        step();
        expect_state("pp_load", 2, 1, 0);
        carga = 1'b0;
        step(); expect_state("pp_5", 5, 0, 1);
        step(); expect_state("pp_8", 8, 0, 0);
        step(); expect_state("pp_clamp9", 9, 0, 0);
        step(); expect_state("pp_6", 6, 1, 0);
        step(); expect_state("pp_3", 3, 1, 0);
        step(); expect_state("pp_clamp2", 2, 1, 0);
        step(); expect_state("pp_5b", 5, 0, 1);

        // Step of zero counts as one
        modo        = 2'b00;
        limite_min  = 4'd0;
        limite_max  = 4'd15;
        passo       = 4'd0;
        carga       = 1'b1;
        valor_carga = 4'd5;
        step();
        expect_state("p0_load", 5, 0, 0);
        carga = 1'b0;
        step(); expect_state("p0_inc", 6, 0, 0);

        // Load clamps to max and is honoured with enable low
        enable      = 1'b0;
        limite_max  = 4'd10;
        passo       = 4'd1;
        carga       = 1'b1;
        valor_carga = 4'd14;
        step();
        expect_state("ld_clamp", 10, 0, 0);
        carga = 1'b0;
        step(); expect_state("en0_hold1", 10, 0, 0);
        step(); expect_state("en0_hold2", 10, 0, 0);

        // Hold mode
        enable = 1'b1;
        modo   = 2'b11;
        step(); expect_state("hold", 10, 0, 0);

        // Bound fault freezes everything, including load
        limite_max  = 4'd15;
        carga       = 1'b1;
        valor_carga = 4'd8;
        step();
        expect_state("flt_load", 8, 0, 0);
        carga      = 1'b0;
        modo       = 2'b10;
        limite_min = 4'd8;
        limite_max = 4'd5;
        #1;
        check("flt_erro", int'(erro), 1);
        step(); expect_state("flt_frz1", 8, 0, 0);
        step(); expect_state("flt_frz2", 8, 0, 0);
        carga       = 1'b1;
        valor_carga = 4'd3;
        step(); expect_state("flt_noload", 8, 0, 0);
        carga      = 1'b0;
        limite_min = 4'd1;
        limite_max = 4'd5;
        #1;
        check("flt_erro_clr", int'(erro), 0);
        step(); expect_state("oor_fix", 1, 0, 0);

        // Reset beats load mid-descent
        limite_min  = 4'd0;
        limite_max  = 4'd15;
        carga       = 1'b1;
        valor_carga = 4'd10;
        step();
        expect_state("rst_pre_load", 10, 0, 0);
        carga = 1'b0;
        modo  = 2'b01;
        step(); expect_state("rst_pre_dn", 9, 1, 0);
        modo        = 2'b10;
        resert      = 1'b1;
        carga       = 1'b1;
        valor_carga = 4'd5;
        step(); expect_state("rst_mid", 0, 0, 0);
        resert = 1'b0;
        carga  = 1'b0;
        step(); expect_state("rst_after", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_ud_param.md
Name: contador_ud_param

Overview:
- Parametrised successor to the team's fixed 4-bit bouncing up/down counter.
- Generalises to WIDTH bits with runtime lower/upper bounds, step size and four modes: up-wrap, down-wrap, ping-pong, hold.
- Adds count enable, synchronous load and a cycle-complete pulse.
- Used as a general timebase / sweep generator in the exercise designs.

Parameters:
WIDTH, 4, counter and bound width in bits.
MODO_RESET, 2'b10, mode assumed for documentation of reset defaults only. No effect on RTL; ping-pong is the nominal use.

Ports:
clock  input  1  system clock, all state updates on rising edge.
resert  input  1  synchronous reset, active-high.
enable  input  1  count enable; when 0, saida and direcao hold (load still honoured).
modo  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold.
carga  input  1  synchronous load strobe.
valor_carga  input  WIDTH  load value.
passo  input  WIDTH  step size; 0 treated as 1.
limite_min  input  WIDTH  lower bound, inclusive.
limite_max  input  WIDTH  upper bound, inclusive.
saida  output  WIDTH  registered count.
direcao  output  1  registered direction, 0 = up, 1 = down.
fim_ciclo  output  1  registered one-cycle pulse on wrap or completed ping-pong cycle.
erro  output  1  combinational, high while limite_min > limite_max.

Behaviour:
- Reset (resert=1 at edge) sets saida=0, direcao=0, fim_ciclo=0. Reset has highest priority, including mid-count and mid-load.
- Priority per edge: resert > erro (hold all, fim_ciclo=0) > carga > out-of-range fix > enable/modo count.
- All arithmetic is done in WIDTH+1 bits. No intermediate overflow is permitted. Let p = max(passo,1).
- Load:
  - saida <= valor_carga clamped to [limite_min, limite_max]. direcao unchanged. fim_ciclo=0.
  - Load is independent of enable.
- Out-of-range: if enable=1, modo!=11 and saida is outside [min,max], then saida <= limite_min, direcao <= 0, fim_ciclo=0.
- Up-wrap (00):
  - If saida+p > max, then saida <= min and fim_ciclo=1.
  - Else saida <= saida+p.
  - direcao forced to 0.
- Down-wrap (01):
  - If saida < min+p, then saida <= max and fim_ciclo=1.
  - Else saida <= saida-p.
  - direcao forced to 1.
- Ping-pong (10):
  - Up (direcao=0):
    - If saida == max: saida <= max(saida-p, min) and direcao <= 1. This reverses with no dwell: max is held for exactly one cycle.
    - Else if saida+p > max: saida <= max.
    - Else saida <= saida+p.
  - Down (direcao=1):
    - If saida == min: saida <= min(saida+p, max), direcao <= 0 and fim_ciclo=1.
    - Else if saida < min+p: saida <= min.
    - Else saida <= saida-p.
  - If min == max, saida stays at min. direcao toggles each enabled cycle. fim_ciclo pulses on every up transition.
- Hold (11): saida and direcao hold, fim_ciclo=0.
- fim_ciclo is 0 on any cycle without a qualifying event, including enable=0.
- Changing modo mid-count takes effect on the next edge with no reset. direcao is kept in ping-pong, or forced as above in the wrap modes.
- Bounds may change at any time. They are sampled each edge.
- With WIDTH=4, min=0, max=15, passo=1, modo=10, the sequence matches the legacy counter exactly: 0..15,14..0,1...

Test Plan:
- Legacy equivalence: WIDTH=4, min=0, max=15, passo=1, modo=10, enable=1, reset released -> saida 0,1,...,15,14,...,0,1. fim_ciclo high only on the edge leaving 0 after a descent. direcao=1 from saida=14 through 0.
- Up-wrap with step: min=3, max=12, passo=4, modo=00, load 3 -> 3,7,11,3,7. fim_ciclo pulses on each 11->3.
- Down-wrap / ping-pong clamp: down-wrap min=2, max=9, passo=3, from 9 -> 9,6,3,9. Ping-pong same bounds from 2 -> 2,5,8,9,6,3,2,5.
- Load and enable: enable=0, carga=1, valor_carga=14 with max=10 -> saida=10 next edge. Subsequent edges with enable=0 -> saida holds at 10, fim_ciclo=0.
- Fault cases: set min=8, max=5 -> erro=1 and saida frozen. Restore min=1, max=5 with saida=8 -> next enabled edge saida=1, direcao=0.
- Reset mid-operation: assert resert during ping-pong descent at saida=9 with carga=1 -> saida=0, direcao=0, fim_ciclo=0 next edge.
